gray_encoder_stream: RTL and testbench
======================================

# gray_encoder_stream

Streaming binary-to-Gray encoder with valid/ready handshakes on both sides and a 2-entry skid buffer, so every path is registered and no word is lost under backpressure. It is the transmit-side counterpart of the team's `gray_to_binary` decoder. It also checks the unit-distance property of the emitted stream and counts completed transfers. Its output feeds `gray_to_binary` or any Gray-pointer consumer.

## Interface
- `WIDTH`, 4: data width in bits, must be ≥ 2.
- `CNT_W`, 16: width of the transfer counter.

- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream presents `in_bin`.
- `in_ready`  output  1  block can accept a word; registered.
- `in_bin`  input  WIDTH  binary word.
- `out_valid`  output  1  `out_gray` is valid.
- `out_ready`  input  1  downstream accepts the word.
- `out_gray`  output  WIDTH  Gray encoding of the binary word.
- `out_bin`  output  WIDTH  original binary word, aligned with `out_gray`.
- `out_adj`  output  1  high when `out_gray` differs from the previously transferred Gray word in exactly one bit.
- `xfer_cnt`  output  CNT_W  number of output transfers since reset.

## Operation
- Encoding: G = B ^ (B >> 1), i.e. G[WIDTH-1] = B[WIDTH-1] and G[i] = B[i+1] ^ B[i]. The encoding is computed at input acceptance and stored.
- Handshake events:
  - Input accept: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
  - Data must not change in a cycle where the producing side holds valid high and ready is low.
- Storage: output register OR (drives the outputs) and skid register SR. Each has a valid bit; `out_valid` = OR valid.
- `in_ready` = !SR valid, registered.
- Next-state rules, evaluated per cycle:
  - Accept and (OR empty or output transfer): word loads into OR.
  - Accept, OR full and no transfer: word loads into SR.
  - No accept, SR full and transfer: SR moves to OR and SR empties.
  - No accept, no SR, and transfer: OR empties.
  - Accept while SR full cannot occur, because `in_ready` is 0.
- Ordering is strict FIFO, with a maximum of 2 words in flight.
- `out_adj`:
  - Computed combinationally: popcount(`out_gray` ^ LAST) == 1, where LAST is the Gray word of the most recent output transfer.
  - For the first transfer after reset, `out_adj` is forced to 1.
  - LAST updates only on an output transfer.
- `xfer_cnt`: increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Reset, from any state including mid-transfer:
  - OR and SR are invalidated, so in-flight words are discarded.
  - `out_valid` = 0, `in_ready` = 1, `out_gray` = 0, `out_bin` = 0, `xfer_cnt` = 0.
  - LAST = 0 and the first-transfer flag is set, so `out_adj` = 1.

## Timing
- Latency: a word accepted at edge N is presented on `out_gray` after edge N, i.e. visible in cycle N+1. It is 1 cycle with no stall.
- Throughput: 1 word per cycle while `out_ready` = 1 continuously.
- Backpressure:
  - `out_ready` low with OR full: one further word is accepted into SR, then `in_ready` falls after that edge.
  - `in_ready` rises one cycle after the transfer that drains SR.
- Simultaneous accept and transfer with OR full and SR empty: the new word replaces OR, and there is no bubble.
- `out_valid` and `in_ready` are flop outputs. `out_adj` is the only combinational output, and it depends only on registered state.
- Reset is taken on the rising edge while `rst` = 1, and the handshake inputs are ignored in that cycle.

## Test plan
- Sweep `in_bin` = 0..15 in consecutive cycles, `WIDTH` = 4, `out_ready` = 1. Required:
  - `out_gray` = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, each one cycle after its input.
  - `out_adj` = 1 throughout and `xfer_cnt` reaches 16.
- Wrap-around: send 15 then 0. Required: `out_gray` 8 then 0, with `out_adj` = 1 on both.
- Backpressure:
  - Stimulus: `in_valid` = 1 with words 1,2,3, and `out_ready` held 0 for 3 cycles.
  - Required: 1 is held in OR and 2 in SR, `in_ready` = 0 after the 2nd accept, and 3 is accepted only after release.
  - Required: outputs 1,3,2 (Gray of 1,2,3) in order, with nothing lost or duplicated.
- Non-adjacent detection: send 0 then 5. Required: second `out_gray` = 7, `out_bin` = 5, `out_adj` = 0.
- Reset mid-operation: assert `rst` with both registers full and `out_ready` = 0. Required:
  - Next cycle: `out_valid` = 0, `in_ready` = 1, `xfer_cnt` = 0.
  - First post-reset transfer has `out_adj` = 1.
- Counter wrap with `CNT_W` = 4: 17 transfers. Required: `xfer_cnt` reads 1.

Source files
------------

// File: rtl/gray_encoder_stream.sv
// Streaming binary-to-Gray encoder with a 2-entry skid buffer (output + skid register).
// It also flags unit-distance steps in the emitted Gray stream and counts output transfers.
module gray_encoder_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_adj,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             or_valid_q, or_valid_d;
    logic [WIDTH-1:0] or_gray_q, or_gray_d;
    logic [WIDTH-1:0] or_bin_q, or_bin_d;
    logic             sr_valid_q, sr_valid_d;
    logic [WIDTH-1:0] sr_gray_q, sr_gray_d;
    logic [WIDTH-1:0] sr_bin_q, sr_bin_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] in_gray;
    logic [WIDTH-1:0] diff;

    always_comb begin
        accept     = in_valid && in_ready_q;
        xfer       = or_valid_q && out_ready;
        in_gray    = in_bin ^ (in_bin >> 1);

        or_valid_d = or_valid_q;
        or_gray_d  = or_gray_q;
        or_bin_d   = or_bin_q;
        sr_valid_d = sr_valid_q;
        sr_gray_d  = sr_gray_q;
        sr_bin_d   = sr_bin_q;
        last_d     = last_q;
        first_d    = first_q;
        cnt_d      = cnt_q;

        // in_ready_q mirrors !sr_valid_q, so an accept never coincides with a full skid register
        if (accept && (!or_valid_q || xfer)) begin
            or_valid_d = 1'b1;
            or_gray_d  = in_gray;
            or_bin_d   = in_bin;
        end else if (accept) begin
            sr_valid_d = 1'b1;
            sr_gray_d  = in_gray;
            sr_bin_d   = in_bin;
        end else if (xfer && sr_valid_q) begin
            or_gray_d  = sr_gray_q;
            or_bin_d   = sr_bin_q;
            sr_valid_d = 1'b0;
        end else if (xfer) begin
            or_valid_d = 1'b0;
        end

        in_ready_d = !sr_valid_d;

        if (xfer) begin
            last_d  = or_gray_q;
            first_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_gray_q  <= '0;
            or_bin_q   <= '0;
            sr_valid_q <= 1'b0;
            sr_gray_q  <= '0;
            sr_bin_q   <= '0;
            in_ready_q <= 1'b1;
            last_q     <= '0;
            first_q    <= 1'b1;
            cnt_q      <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_gray_q  <= or_gray_d;
            or_bin_q   <= or_bin_d;
            sr_valid_q <= sr_valid_d;
            sr_gray_q  <= sr_gray_d;
            sr_bin_q   <= sr_bin_d;
            in_ready_q <= in_ready_d;
            last_q     <= last_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    always_comb begin
        diff    = or_gray_q ^ last_q;
        out_adj = first_q || ((diff != '0) && ((diff & (diff - WIDTH'(1))) == '0));
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid_q;
    assign out_gray  = or_gray_q;
    assign out_bin   = or_bin_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_encoder_stream.sv
// Bench for gray_encoder_stream: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_gray_encoder_stream;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_bin;

    logic         in_ready, out_valid, out_adj;
    logic [W-1:0] out_gray, out_bin;
    logic [15:0]  xfer_cnt;

    logic         in_ready4, out_valid4, out_adj4;
    logic [W-1:0] out_gray4, out_bin4;
    logic [3:0]   xfer_cnt4;

    gray_encoder_stream #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray), .out_bin(out_bin),
        .out_adj(out_adj), .xfer_cnt(xfer_cnt)
    );

    gray_encoder_stream #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_bin(in_bin),
        .out_valid(out_valid4), .out_ready(out_ready), .out_gray(out_gray4), .out_bin(out_bin4),
        .out_adj(out_adj4), .xfer_cnt(xfer_cnt4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: words in flight as a plain FIFO of binary values (at most 2)
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    bit           m_first;
    int unsigned  m_cnt;
    bit           m_acc;
    bit           m_xf;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_last  = '0;
            m_first = 1'b1;
            m_cnt   = 0;
            m_acc   = 1'b0;
        end else begin
            m_xf  = (mq.size() > 0) && out_ready;
            m_acc = in_valid && (mq.size() < 2);
            if (m_xf) begin
                m_last  = g(mq[0]);
                m_first = 1'b0;
                m_cnt++;
                void'(mq.pop_front());
            end
            if (m_acc) mq.push_back(in_bin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("out_valid4", 32'(out_valid4), 32'(mq.size() > 0));
            chk("xfer_cnt", 32'(xfer_cnt), m_cnt % 65536);
            chk("xfer_cnt4", 32'(xfer_cnt4), m_cnt % 16);
            if (mq.size() > 0) begin
                chk("out_gray", 32'(out_gray), 32'(g(mq[0])));
                chk("out_bin", 32'(out_bin), 32'(mq[0]));
                chk("out_adj", 32'(out_adj),
                    32'(m_first || ($countones(g(mq[0]) ^ m_last) == 1)));
            end
        end
    end

    // Apply inputs, then let one rising edge pass; return 2 time units after it
    task automatic cyc(input bit v, input logic [W-1:0] b, input bit r);
        in_valid  = v;
        in_bin    = b;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    logic [W-1:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [15:0]  cnt0;
    bit           rv;
    logic [W-1:0] rb;

    initial begin
        rst = 1'b1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_gray", 32'(out_gray), 32'd0);
        chk("rst_out_bin", 32'(out_bin), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_out_adj", 32'(out_adj), 32'd1);
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(1, W'(i), 1);
            chk("sweep_gray", 32'(out_gray), 32'(gtab[i]));
            chk("sweep_adj", 32'(out_adj), 32'd1);
        end
        cyc(0, '0, 1);
        chk("sweep_cnt", 32'(xfer_cnt), 32'd16);

        cyc(1, 4'd14, 1);
        cyc(1, 4'd15, 1);
        chk("wrap_gray15", 32'(out_gray), 32'h8);
        chk("wrap_adj15", 32'(out_adj), 32'd1);
        cyc(1, 4'd0, 1);
        chk("wrap_gray0", 32'(out_gray), 32'h0);
        chk("wrap_adj0", 32'(out_adj), 32'd1);
        cyc(0, '0, 1);

        cnt0 = xfer_cnt;
        cyc(1, 4'd1, 0);
        chk("bp_or1", 32'(out_gray), 32'h1);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        cyc(1, 4'd2, 0);
        chk("bp_ready0", 32'(in_ready), 32'd0);
        chk("bp_hold1", 32'(out_gray), 32'h1);
        cyc(1, 4'd3, 0);
        chk("bp_still1", 32'(out_gray), 32'h1);
        chk("bp_still_ready0", 32'(in_ready), 32'd0);
        cyc(1, 4'd3, 1);
        chk("bp_out2", 32'(out_gray), 32'h3);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        cyc(1, 4'd3, 1);
        chk("bp_out3", 32'(out_gray), 32'h2);
        chk("bp_bin3", 32'(out_bin), 32'h3);
        cyc(0, '0, 1);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(xfer_cnt - cnt0), 32'd3);

        cyc(1, 4'd0, 1);
        chk("na_gray0", 32'(out_gray), 32'h0);
        cyc(1, 4'd5, 1);
        chk("na_gray", 32'(out_gray), 32'h7);
        chk("na_bin", 32'(out_bin), 32'h5);
        chk("na_adj", 32'(out_adj), 32'd0);
        cyc(0, '0, 1);

        cyc(1, 4'd1, 0);
        cyc(1, 4'd2, 0);
        chk("mr_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cyc(1, 4'd3, 0);
        rst = 1'b0;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_xfer_cnt", 32'(xfer_cnt), 32'd0);
        cyc(1, 4'd6, 1);
        chk("mr_first_gray", 32'(out_gray), 32'h5);
        chk("mr_first_adj", 32'(out_adj), 32'd1);
        cyc(0, '0, 1);
        cyc(1, 4'd0, 1);
        chk("mr_second_adj", 32'(out_adj), 32'd0);
        cyc(0, '0, 1);

        rst = 1'b1;
        cyc(0, '0, 0);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) cyc(1, W'(i), 1);
        cyc(0, '0, 1);
        chk("cnt4_wrap", 32'(xfer_cnt4), 32'd1);
        chk("cnt16_17", 32'(xfer_cnt), 32'd17);

        rv = 1'b0;
        rb = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (!(rv && !m_acc)) begin
                rv = ($urandom_range(0, 3) != 0);
                rb = ($urandom_range(0, 1) != 0) ? W'(rb + 1'b1) : W'($urandom);
            end
            cyc(rv, rb, $urandom_range(0, 2) != 0);
        end
        rst = 1'b0;
        cyc(0, '0, 1);
        cyc(0, '0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
